// File: rtl/scan_pkg.sv
// ============================================================================
//  scan_pkg
//  Shared sizes and state encoding for the channel-scan sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

package scan_pkg;
   localparam int CH_N  = 16;
   localparam int IDX_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } scan_state_t;
endpackage

`default_nettype wire

// File: rtl/scan_sequencer_if.sv
// ============================================================================
//  scan_sequencer_if
//  Control/status bundle between a scan controller and the sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface scan_sequencer_if #(
   parameter int DIV_W = 8
);
   import scan_pkg::*;

   logic                 start;
   logic                 stop;
   logic                 mode;
   logic [DIV_W-1:0]     div;
   logic [CH_N-1:0]      ch_mask;
   logic [IDX_W-1:0]     idx;
   logic                 idx_valid;
   logic                 tick;
   logic                 pass_done;
   logic                 busy;

   modport master (
      output start, stop, mode, div, ch_mask,
      input  idx, idx_valid, tick, pass_done, busy
   );

   modport slave (
      input  start, stop, mode, div, ch_mask,
      output idx, idx_valid, tick, pass_done, busy
   );
endinterface

`default_nettype wire

// File: rtl/next_channel_find.sv
// ============================================================================
//  next_channel_find
//  Combinational search for the next enabled channel above cur, and the lowest.
//  Rev 1.0
// ============================================================================
`default_nettype none

module next_channel_find
   import scan_pkg::*;
(
   input  wire logic [CH_N-1:0]  mask,
   input  wire logic [IDX_W-1:0] cur,
   output logic      [IDX_W-1:0] nxt,
   output logic                  found,
   output logic      [IDX_W-1:0] first,
   output logic                  any
);

   // Scanning downward lets the lowest qualifying bit be the last writer.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      first = '0;
      for (int i = CH_N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first = IDX_W'(i);
            if (i > int'(cur)) begin
               nxt   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end
   end

   assign any = |mask;

endmodule

`default_nettype wire

// File: rtl/scan_sequencer.sv
// ============================================================================
//  scan_sequencer
//  Steps a 4-bit channel index through a live mask with a programmable dwell.
//  Rev 1.0
// ============================================================================
`default_nettype none

module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DIV_W = 8
)(
   input  wire logic       clk,
   input  wire logic       rst_n,
   scan_sequencer_if.slave bus
);

   scan_state_t        r_state, w_state_d;
   logic [IDX_W-1:0]   r_idx, w_idx_d;
   logic               r_tick, w_tick_d;
   logic               r_pass_done, w_pass_done_d;
   logic [DIV_W-1:0]   r_cnt, w_cnt_d;
   logic [DIV_W-1:0]   r_div, w_div_d;
   logic               r_mode, w_mode_d;

   logic [IDX_W-1:0]   w_nxt;
   logic               w_found;
   logic [IDX_W-1:0]   w_first;
   logic               w_any;

   next_channel_find u_find (
      .mask  (bus.ch_mask),
      .cur   (r_idx),
      .nxt   (w_nxt),
      .found (w_found),
      .first (w_first),
      .any   (w_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_tick      <= 1'b0;
         r_pass_done <= 1'b0;
         r_cnt       <= '0;
         r_div       <= '0;
         r_mode      <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_idx       <= w_idx_d;
         r_tick      <= w_tick_d;
         r_pass_done <= w_pass_done_d;
         r_cnt       <= w_cnt_d;
         r_div       <= w_div_d;
         r_mode      <= w_mode_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_idx_d       = r_idx;
      w_tick_d      = 1'b0;
      w_pass_done_d = 1'b0;
      w_cnt_d       = r_cnt;
      w_div_d       = r_div;
      w_mode_d      = r_mode;

      case (r_state)
         IDLE: begin
            if (bus.start && !bus.stop && w_any) begin
               w_state_d = RUN;
               w_idx_d   = w_first;
               w_tick_d  = 1'b1;
               w_cnt_d   = '0;
               w_mode_d  = bus.mode;
               w_div_d   = bus.div;
            end
         end
         RUN: begin
            if (bus.stop) begin
               w_state_d = IDLE;
               w_cnt_d   = '0;
            end else if (r_cnt == r_div) begin
               w_cnt_d = '0;
               if (w_found) begin
                  w_idx_d  = w_nxt;
                  w_tick_d = 1'b1;
               end else begin
                  w_pass_done_d = 1'b1;
                  // A mask emptied mid-run ends the scan even in continuous mode.
                  if (!r_mode && w_any) begin
                     w_idx_d  = w_first;
                     w_tick_d = 1'b1;
                  end else begin
                     w_state_d = IDLE;
                  end
               end
            end else begin
               w_cnt_d = r_cnt + DIV_W'(1);
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   assign bus.idx       = r_idx;
   assign bus.idx_valid = (r_state == RUN);
   assign bus.busy      = (r_state == RUN);
   assign bus.tick      = r_tick;
   assign bus.pass_done = r_pass_done;

endmodule

`default_nettype wire
